// File: rtl/serial_sub_2_pkg.sv
// Shared constants and state encoding for the digit-serial subtractor.
package serial_sub_2_pkg;
  localparam int WIDTH_DEF  = 8;
  localparam int DIGIT_BITS = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/serial_sub_2_bla_2.sv
// 2-bit borrow-lookahead digit slice: dd = a - b - brw_in with group generate/propagate.
module bla_2
  import serial_sub_2_pkg::*;
(
  input  logic [DIGIT_BITS-1:0] a,
  input  logic [DIGIT_BITS-1:0] b,
  input  logic                  brw_in,
  output logic [DIGIT_BITS-1:0] dd,
  output logic                  g_out,
  output logic                  p_out,
  output logic                  brw_out
);
  logic [1:0] g_bit;
  logic [1:0] p_bit;
  logic       brw_mid;

  // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
  assign g_bit   = ~a & b;
  assign p_bit   = ~(a ^ b);
  assign brw_mid = g_bit[0] | (p_bit[0] & brw_in);

  assign dd[0]   = a[0] ^ b[0] ^ brw_in;
  assign dd[1]   = a[1] ^ b[1] ^ brw_mid;

  assign g_out   = g_bit[1] | (p_bit[1] & g_bit[0]);
  assign p_out   = p_bit[1] & p_bit[0];
  assign brw_out = g_out | (p_out & brw_in);
endmodule

// File: rtl/serial_sub_2.sv
// Digit-serial subtractor, 2 bits per clock, LSB digit first; holds result and flags until next op.
//   state | meaning
//   IDLE  | waiting for start, result and flags held
//   RUN   | one digit processed per cycle, DIGITS cycles total
module serial_sub_2
  import serial_sub_2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             zero,
  output logic             ovf
);
  localparam int DIGITS = WIDTH / DIGIT_BITS;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, d_q;
  logic            brw_q, a_msb_q, b_msb_q;
  logic            busy_q, done_q, b_out_q, zero_q, ovf_q;

  logic [DIGIT_BITS-1:0] dd;
  logic            g_dig, p_dig, brw_d;
  logic            unused_gp;
  logic [WIDTH-1:0] res_d;

  bla_2 u_bla_2 (
    .a       (a_q[DIGIT_BITS-1:0]),
    .b       (b_q[DIGIT_BITS-1:0]),
    .brw_in  (brw_q),
    .dd      (dd),
    .g_out   (g_dig),
    .p_out   (p_dig),
    .brw_out (brw_d)
  );

  // Group generate/propagate are only needed when slices are chained in parallel.
  assign unused_gp = g_dig & p_dig;

  // New digit enters at the top so the LSB digit ends up at bit 0 after DIGITS shifts.
  assign res_d = (res_q >> DIGIT_BITS) | (WIDTH'(dd) << (WIDTH - DIGIT_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      b_out_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= b_in;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> DIGIT_BITS;
          b_q   <= b_q >> DIGIT_BITS;
          brw_q <= brw_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            d_q     <= res_d;
            b_out_q <= brw_d;
            zero_q  <= (res_d == '0);
            ovf_q   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign d     = d_q;
  assign b_out = b_out_q;
  assign zero  = zero_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_serial_sub_2.sv
// Self-checking bench for serial_sub_2 (WIDTH=8): scoreboard of expected results popped on done.
module tb_serial_sub_2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         b_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, b_out, zero, ovf;
  logic [W-1:0] d;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         v;
  } exp_t;

  exp_t         exp_q[$];
  int           nvec = 0;
  int           nmis = 0;
  logic [W-1:0] last_d = '0;
  int           done_seen = 0;

  serial_sub_2 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    if (obs !== expv) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    int   ux, uy, sx, sy, ud, sd;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    ud = ux - uy - int'(bi);
    sd = sx - sy - int'(bi);
    e.d  = W'(ud & 255);
    e.bo = (ud < 0);
    e.z  = ((ud & 255) == 0);
    e.v  = (sd > 127) || (sd < -128);
    return e;
  endfunction

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    e = model(x, y, bi);
    a = x;
    b = y;
    b_in = bi;
    start = 1'b1;
    exp_q.push_back(e);
    last_d = e.d;
  endtask

  // Walks the 4 RUN cycles; optionally fires a start mid-run that must be ignored.
  task automatic run_op(input bit inject);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      if (inject && i == 1) begin
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
      end
      if (inject && i == 2) start = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
  endtask

  task automatic hold_chk();
    @(negedge clk);
    chk("done_drop", done, 0);
    chk("d_hold", d, last_d);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_seen++;
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("d", d, e.d);
        chk("b_out", b_out, e.bo);
        chk("zero", zero, e.z);
        chk("ovf", ovf, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] tv_a [6];
    logic [W-1:0] tv_b [6];
    logic         tv_c [6];
    int           seen0;
    tv_a = '{8'h10, 8'h80, 8'h7F, 8'h33, 8'h00, 8'hFF};
    tv_b = '{8'h20, 8'h01, 8'hFF, 8'h32, 8'h00, 8'hFF};
    tv_c = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_bout", b_out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);

    // First op with a start fired mid-run that must not disturb it.
    @(posedge clk);
    #1 launch(8'h5A, 8'h23, 1'b0);
    run_op(1'b1);
    hold_chk();
    chk("d_0x37", d, 8'h37);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 launch(tv_a[i], tv_b[i], tv_c[i]);
      run_op(1'b0);
      hold_chk();
    end

    // Start in the done cycle is accepted back to back.
    @(posedge clk);
    #1 launch(8'h10, 8'h20, 1'b0);
    run_op(1'b0);
    launch(8'hC3, 8'h3C, 1'b1);
    run_op(1'b0);
    hold_chk();

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 launch(W'($urandom_range(255)), W'($urandom_range(255)), 1'($urandom_range(1)));
      run_op(1'b0);
      hold_chk();
    end

    @(posedge clk);
    #1 launch(8'h5A, 8'h23, 1'b0);
    run_op(1'b0);
    hold_chk();

    // Abort during the second RUN cycle; nothing is pushed for this op.
    @(posedge clk);
    #1;
    a = 8'h44;
    b = 8'h11;
    b_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_d", d, 0);
    chk("abort_bout", b_out, 0);
    chk("abort_zero", zero, 0);
    chk("abort_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen0 = done_seen;
    repeat (8) @(negedge clk);
    chk("no_done_after_abort", done_seen, seen0);
    chk("idle_after_abort", busy, 0);

    @(posedge clk);
    #1 launch(8'h80, 8'h01, 1'b0);
    run_op(1'b0);
    hold_chk();

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
